uart_baud_gen: RTL

Programmable two-stage UART baud/oversample tick generator that succeeds the fixed-width overflow counter used in the transmitter. A prescaler divides `i_clk` by a run-time divisor to produce an oversample tick. An oversample counter then derives a bit tick and a mid-bit tick from it. The block feeds both UART_TX (bit tick) and UART_RX (oversample and mid-bit ticks). It supports glitch-free divisor changes and phase restart for RX start-bit alignment.

---
 rtl/uart_baud_gen_pkg.sv | 20 ++
 rtl/uart_baud_gen_mod_counter.sv | 48 ++++
 rtl/uart_baud_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_baud_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen_pkg
//  Purpose  : Shared defaults and types for the UART baud/oversample ticks.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_baud_gen_pkg;

    localparam int DEF_DIV_WIDTH = 16;
    localparam int DEF_OSR       = 16;
    localparam int DEF_OSR_WIDTH = 4;

    typedef struct packed {
        logic os;
        logic mid;
        logic bit_end;
    } tick_t;

endpackage : uart_baud_gen_pkg
`default_nettype wire

// File: rtl/uart_baud_gen_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo counter with synchronous clear and combinational wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [WIDTH:0]   i_modulus,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   w_last;

    // One extra modulus bit lets a full 2**WIDTH modulus be expressed.
    assign w_last  = i_modulus - (WIDTH+1)'(1);
    assign o_wrap  = i_enable && ({1'b0, count_q} == w_last);
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (o_wrap) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : mod_counter
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Programmable prescaler + oversample counter giving os/mid/bit ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int OSR       = DEF_OSR,
    parameter int OSR_WIDTH = DEF_OSR_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    input  logic                 i_restart,
    output logic                 o_os_tick,
    output logic                 o_mid_tick,
    output logic                 o_bit_tick,
    output logic [OSR_WIDTH-1:0] o_os_count
);

    localparam logic [OSR_WIDTH:0]   c_osr_mod = (OSR_WIDTH+1)'(OSR);
    localparam logic [OSR_WIDTH-1:0] c_mid_idx = OSR_WIDTH'(OSR/2 - 1);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;
    logic                 started_q;
    logic                 started_d;
    tick_t                ticks_q;
    tick_t                ticks_d;

    logic                 w_use_in;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic                 w_clear;
    logic                 w_p_en;
    logic                 w_p_wrap;
    logic [DIV_WIDTH-1:0] w_prescale_unused;
    logic [OSR_WIDTH-1:0] w_s_count;
    logic                 w_s_wrap;

    // First enabled cycle and the zero-divisor stall count straight from the
    // input so a fresh divisor N yields its first tick on the N-th edge.
    assign w_use_in  = !started_q || (div_q == '0);
    assign w_div_eff = w_use_in ? i_divisor : div_q;
    assign w_clear   = !i_enable || i_restart;
    assign w_p_en    = i_enable && !i_restart && (w_div_eff != '0);

    mod_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_prescale (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_enable  (w_p_en),
        .i_clear   (w_clear),
        .i_modulus ({1'b0, w_div_eff}),
        .o_count   (w_prescale_unused),
        .o_wrap    (w_p_wrap)
    );

    mod_counter #(
        .WIDTH (OSR_WIDTH)
    ) u_oversample (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_enable  (w_p_wrap),
        .i_clear   (w_clear),
        .i_modulus (c_osr_mod),
        .o_count   (w_s_count),
        .o_wrap    (w_s_wrap)
    );

    always_comb begin
        div_d           = div_q;
        started_d       = i_enable;
        ticks_d         = '0;
        ticks_d.os      = w_p_wrap;
        ticks_d.mid     = w_p_wrap && (w_s_count == c_mid_idx);
        ticks_d.bit_end = w_s_wrap;
        if (i_enable && (w_use_in || i_restart || w_p_wrap)) begin
            div_d = i_divisor;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_q     <= '0;
            started_q <= 1'b0;
            ticks_q   <= '0;
        end else begin
            div_q     <= div_d;
            started_q <= started_d;
            ticks_q   <= ticks_d;
        end
    end

    assign o_os_tick  = ticks_q.os;
    assign o_mid_tick = ticks_q.mid;
    assign o_bit_tick = ticks_q.bit_end;
    assign o_os_count = w_s_count;

endmodule : uart_baud_gen
`default_nettype wire
